// File: rtl/commit_checker.sv
// Lockstep commit checker: buffers DUT retirement records and compares them
// in order against a golden model. Optional watchdog: COMMIT_CHECKER_TIMEOUT_EN.
module commit_checker #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         dut_valid_i,
    input  logic [165:0] dut_rec_i,
    input  logic         gold_valid_i,
    output logic         gold_ready_o,
    input  logic [165:0] gold_rec_i,
    output logic [31:0]  match_count_o,
    output logic         mismatch_o,
    output logic [165:0] mismatch_dut_o,
    output logic [165:0] mismatch_gold_o,
    output logic         overflow_o,
    output logic         timeout_o,
    output logic         fail_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("commit_checker: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        is_store;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
    } rec_t;

    typedef enum logic {S_RUN, S_FAIL} state_t;

    state_t          r_state, w_state_next;
    logic [165:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_match_count;
    logic            r_mismatch, r_overflow;
    logic [165:0]    r_mis_dut, r_mis_gold;

    rec_t w_head, w_gold;
    logic w_run, w_full, w_pop, w_push, w_overflow, w_match, w_timeout_hit;

    assign w_head = r_mem[r_rd_ptr];
    assign w_gold = gold_rec_i;
    assign w_run  = (r_state == S_RUN);
    assign w_full = (r_count == FULL_COUNT);

    // Only the head is visible to gold, so a record pushed this cycle is never compared this cycle.
    assign w_pop      = gold_valid_i & gold_ready_o;
    assign w_push     = w_run & dut_valid_i & (~w_full | w_pop);
    assign w_overflow = w_run & dut_valid_i & w_full & ~w_pop;

    always_comb begin
        w_match = (w_head.pc == w_gold.pc) && (w_head.instr == w_gold.instr)
                  && (w_head.is_store == w_gold.is_store);
        if (w_gold.is_store) begin
            w_match = w_match && (w_head.mem_addr == w_gold.mem_addr)
                      && (w_head.mem_data == w_gold.mem_data);
        end else begin
            // x0 writes are architecturally discarded, so their data is don't-care.
            w_match = w_match && (w_head.rd == w_gold.rd)
                      && ((w_gold.rd == 5'd0) || (w_head.rd_data == w_gold.rd_data));
        end
    end

`ifdef COMMIT_CHECKER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [IW-1:0] r_idle;
    logic          r_timeout;
    logic          w_activity;

    assign w_activity    = dut_valid_i | w_pop;
    assign w_timeout_hit = w_run & ~w_activity & (r_idle == IDLE_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_activity || !w_run) r_idle <= '0;
            else if (!w_timeout_hit)  r_idle <= r_idle + 1'b1;
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= S_RUN;
        else         r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        w_state_next = r_state;
        if (w_run && ((w_pop && !w_match) || w_overflow || w_timeout_hit)) begin
            w_state_next = S_FAIL;
        end
    end

    always_comb begin
        fail_o       = (r_state == S_FAIL);
        gold_ready_o = w_run && (r_count != '0);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: storage is cleared too so stale records never reach the capture outputs.
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_match_count <= '0;
            r_mismatch    <= 1'b0;
            r_overflow    <= 1'b0;
            r_mis_dut     <= '0;
            r_mis_gold    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= dut_rec_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop && w_match) r_match_count <= r_match_count + 1'b1;

            if (w_pop && !w_match && !r_mismatch) begin
                r_mismatch <= 1'b1;
                r_mis_dut  <= w_head;
                r_mis_gold <= gold_rec_i;
            end

            if (w_overflow) r_overflow <= 1'b1;
        end
    end

    assign match_count_o   = r_match_count;
    assign mismatch_o      = r_mismatch;
    assign mismatch_dut_o  = r_mis_dut;
    assign mismatch_gold_o = r_mis_gold;
    assign overflow_o      = r_overflow;

endmodule

// File: doc/commit_checker.md
COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning DUT commit records buffered (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle cycles before timeout (used only under REQ-030).
REQ-003 Record layout (166 bits, MSB first) SHALL be pc[31:0], instr[31:0], rd[4:0], rd_data[31:0], is_store, mem_addr[31:0], mem_data[31:0].
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 dut_valid_i  input  1  DUT retired one instruction this cycle; no backpressure.
REQ-007 dut_rec_i  input  166  DUT commit record.
REQ-008 gold_valid_i  input  1  golden-model record available.
REQ-009 gold_ready_o  output  1  checker accepts golden record.
REQ-010 gold_rec_i  input  166  golden commit record.
REQ-011 match_count_o  output  32  records compared equal.
REQ-012 mismatch_o  output  1  sticky compare failure.
REQ-013 mismatch_dut_o / mismatch_gold_o  output  166 each  records captured at first failure.
REQ-014 overflow_o  output  1  sticky: DUT push while FIFO full.
REQ-015 timeout_o  output  1  sticky watchdog expiry.
REQ-016 fail_o  output  1  high in state FAIL.

Function
REQ-017 FSM SHALL have two states: RUN and FAIL; RUN->FAIL on first mismatch, overflow or timeout; FAIL exits only via reset.
REQ-018 In RUN, dut_valid_i SHALL push dut_rec_i into the FIFO the same edge.
REQ-019 gold_ready_o SHALL be high iff state==RUN and FIFO non-empty (no same-cycle bypass from dut_rec_i).
REQ-020 Handshake = gold_valid_i & gold_ready_o; on handshake the FIFO head SHALL pop and be compared with gold_rec_i.
REQ-021 Compare: pc and instr always; if gold is_store: is_store, mem_addr, mem_data; else is_store, rd, and rd_data only when rd!=0.
REQ-022 Compare result SHALL be registered: match_count_o increments, or mismatch_o/fail_o assert, on the edge ending the handshake cycle (1-cycle latency).
REQ-023 On mismatch, mismatch_dut_o/mismatch_gold_o SHALL capture both records; later events never overwrite them.
REQ-024 Push while full with no pop same cycle SHALL set overflow_o, drop the record, enter FAIL.
REQ-025 Push while full with simultaneous pop SHALL be accepted (no overflow).
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH distinguishes full from empty.
REQ-027 In FAIL, pushes ignored, gold_ready_o low, match_count_o frozen.
REQ-028 match_count_o SHALL wrap 0xFFFFFFFF->0 without flagging.

Reset
REQ-029 reset_i SHALL (sync) clear FIFO, pointers, occupancy, match_count_o, all sticky flags, captured records to 0 and set state RUN; reset mid-operation discards buffered records; all outputs 0 the cycle after reset.

Configuration
REQ-030 Macro COMMIT_CHECKER_TIMEOUT_EN: when defined, an idle counter clears on any dut_valid_i or handshake, else increments in RUN; reaching TIMEOUT_CYCLES sets timeout_o and enters FAIL.
REQ-031 Without COMMIT_CHECKER_TIMEOUT_EN, no counter is built and timeout_o is constant 0.

Verification
REQ-032 3 DUT commits pc 0x0,0x4,0x8 x1=0x5, gold identical after 2-cycle delay -> match_count_o=3, mismatch_o=0.
REQ-033 DUT rd=0 rd_data=0xDEAD, gold rd=0 rd_data=0x0 -> match (x0 data ignored); store mem_data 0x12 vs 0x13 -> mismatch_o=1, captured records hold 0x12/0x13, gold_ready_o=0 next cycle.
REQ-034 gold_valid_i=0, 9 consecutive dut_valid_i with FIFO_DEPTH=8 -> overflow_o=1 on 9th push, fail_o=1.
REQ-035 FIFO full, dut_valid_i and handshake same cycle -> no overflow, occupancy stays 8, match_count_o+1.
REQ-036 With macro, TIMEOUT_CYCLES=16, no activity 16 cycles -> timeout_o=1; reset_i pulse -> all outputs 0, state RUN.
